// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider (seq_divider) and
// its single-iteration datapath (div_step).
//   div_state_t   : controller state encoding (IDLE / RUN / DONE)
//   DIV_WIDTH     : default operand/result width
//   DIV_DBZ_FILL  : bit replicated across the quotient on divide-by-zero
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 16;

    // Divide-by-zero quotient is all ones at any width.
    localparam logic DIV_DBZ_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
//   rem_in   : partial remainder (always < divisor between iterations)
//   q_in     : shift register holding unconsumed dividend bits (MSB first)
//              in its upper part and produced quotient bits in its lower part
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after this iteration
//   q_out    : q_in shifted left with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   rem_sh;
    logic             no_borrow;
    logic [WIDTH-1:0] trial;

    always_comb begin
        // {rem, q} shifted left: next dividend MSB enters the remainder.
        rem_sh    = {rem_in, q_in[WIDTH-1]};
        no_borrow = (rem_sh >= {1'b0, divisor});
        // rem_in < divisor, so a successful difference always fits WIDTH bits.
        trial     = rem_sh[WIDTH-1:0] - divisor;
        if (no_borrow) begin
            rem_out = trial;
            q_out   = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = rem_sh[WIDTH-1:0];
            q_out   = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring integer divider, one trial subtraction per cycle.
// An accepted start at edge k gives busy in cycles k+1..k+WIDTH and a
// one-cycle done pulse in cycle k+WIDTH+1; divide-by-zero finishes in k+1
// without ever raising busy. Results hold until the next done.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, sampled only while not busy (also in DONE cycle)
//   dividend     : numerator, captured on accepted start
//   divisor      : denominator, captured on accepted start
//   busy         : iteration in progress
//   done         : one-cycle pulse, results valid
//   quotient     : result quotient
//   remainder    : result remainder
//   div_by_zero  : last operation had divisor == 0
//
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (magnitudes divided, signs restored when the result is loaded; quotient
// truncates toward zero, remainder follows the dividend's sign).
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             accept;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        // Most-negative maps onto itself, which is its correct unsigned magnitude.
        return (v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    assign dvd_mag = magnitude(dividend);
    assign dvs_mag = magnitude(divisor);
    assign q_final = apply_sign(q_nxt, neg_q_r);
    assign r_final = apply_sign(rem_nxt, neg_r_r);
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_final = q_nxt;
    assign r_final = rem_nxt;
`endif

    // RUN is the only state that ignores start.
    assign accept = start && (state != RUN);

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_in  (rem_r),
        .q_in    (q_r),
        .divisor (dvsr_r),
        .rem_out (rem_nxt),
        .q_out   (q_nxt)
    );

    // Working registers: loaded on accept, advanced while running, no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_r  <= '0;
            q_r    <= dvd_mag;
            dvsr_r <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_r <= dividend[WIDTH-1];
`endif
        end else if (state == RUN) begin
            rem_r <= rem_nxt;
            q_r   <= q_nxt;
        end
    end

    // Controller and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Resolved immediately; the iteration is skipped.
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= {WIDTH{DIV_DBZ_FILL}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            count <= '0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (count == CW'(WIDTH - 1)) begin
                        // Last iteration result goes straight to the outputs.
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
